// File: rtl/mips_debug_unit.sv
// ---------------------------------------------------------------------------
// mips_debug_unit
//
// Run-control and state-readout block for the single-cycle MIPS core.
// The core is gated through core_enable; this block decides, cycle by cycle,
// whether the core may retire the instruction at `pc`. It supports run,
// halt, single-step and PC breakpoints, counts retired instructions, and
// serialises debug reads of the core's info banks through a two-cycle
// registered read port.
//
// Ports
//   clk, reset                 single clock, synchronous active-high reset
//   run_req/halt_req/step_req  one-cycle command pulses (halt > step > run)
//   bp_write, bp_index,
//   bp_addr_in, bp_en_in       breakpoint slot programming
//   pc                         PC of the instruction the core would execute
//   core_enable                core advances one instruction when high
//   halted, bp_hit, bp_id      run-control status
//   instret                    retired-instruction counter (wraps)
//   rd_req, rd_sel, rd_addr    debug read request (ignored while rd_busy)
//   rd_busy                    read in flight
//   bank_sel, bank_addr        registered select/address to the info mux
//   bank_data                  combinational info mux result
//   rd_valid, rd_data          one-cycle valid pulse and captured word
// ---------------------------------------------------------------------------
module mips_debug_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_BP     = 2,
    parameter int BP_IDX_W   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run_req,
    input  logic                  halt_req,
    input  logic                  step_req,
    input  logic                  bp_write,
    input  logic [BP_IDX_W-1:0]   bp_index,
    input  logic [DATA_WIDTH-1:0] bp_addr_in,
    input  logic                  bp_en_in,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic                  core_enable,
    output logic                  halted,
    output logic                  bp_hit,
    output logic [BP_IDX_W-1:0]   bp_id,
    output logic [DATA_WIDTH-1:0] instret,
    input  logic                  rd_req,
    input  logic [1:0]            rd_sel,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_busy,
    output logic [1:0]            bank_sel,
    output logic [ADDR_WIDTH-1:0] bank_addr,
    input  logic [DATA_WIDTH-1:0] bank_data,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data
);

    typedef enum logic [1:0] {
        ST_HALTED  = 2'd0,
        ST_RUNNING = 2'd1,
        ST_STEP    = 2'd2
    } state_t;

    state_t                             state_q, state_d;
    logic                               skip_bp_q, skip_bp_d;
    logic                               bp_hit_q, bp_hit_d;
    logic [BP_IDX_W-1:0]                bp_id_q, bp_id_d;
    logic [DATA_WIDTH-1:0]              instret_q, instret_d;
    logic [NUM_BP-1:0][DATA_WIDTH-1:0]  bp_addr_q, bp_addr_d;
    logic [NUM_BP-1:0]                  bp_en_q, bp_en_d;

    logic                               rd_busy_q, rd_busy_d;
    logic                               rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]              rd_data_q, rd_data_d;
    logic [1:0]                         bank_sel_q, bank_sel_d;
    logic [ADDR_WIDTH-1:0]              bank_addr_q, bank_addr_d;

    logic                               any_match;
    logic [BP_IDX_W-1:0]                match_idx;
    logic                               bp_match;

    // Scan from the top slot down so the lowest matching slot wins.
    always_comb begin
        any_match = 1'b0;
        match_idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_en_q[i] && (bp_addr_q[i] == pc)) begin
                any_match = 1'b1;
                match_idx = BP_IDX_W'(i);
            end
        end
    end

    // skip_bp lets a resume step over the breakpoint it stopped on.
    assign bp_match = any_match && !skip_bp_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_HALTED;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALTED: begin
                if (!halt_req) begin
                    if (step_req)     state_d = ST_STEP;
                    else if (run_req) state_d = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (halt_req || bp_match) state_d = ST_HALTED;
            end
            ST_STEP:  state_d = ST_HALTED;
            default:  state_d = ST_HALTED;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // halt_req and a breakpoint match both block the current instruction.
    always_comb begin
        core_enable = 1'b0;
        case (state_q)
            ST_RUNNING: core_enable = !halt_req && !bp_match;
            ST_STEP:    core_enable = 1'b1;
            default:    core_enable = 1'b0;
        endcase
    end

    assign halted = (state_q == ST_HALTED);

    // ---------------- run-control datapath ----------------
    always_comb begin
        skip_bp_d = skip_bp_q;
        bp_hit_d  = bp_hit_q;
        bp_id_d   = bp_id_q;
        instret_d = instret_q + {{(DATA_WIDTH-1){1'b0}}, core_enable};
        bp_addr_d = bp_addr_q;
        bp_en_d   = bp_en_q;

        if ((state_q == ST_HALTED) && !halt_req) begin
            if (step_req) begin
                bp_hit_d = 1'b0;
            end else if (run_req) begin
                bp_hit_d  = 1'b1 ^ 1'b1;
                skip_bp_d = 1'b1;
            end
        end

        if (state_q == ST_RUNNING) begin
            if (!halt_req && bp_match) begin
                bp_hit_d = 1'b1;
                bp_id_d  = match_idx;
            end
            if (core_enable) skip_bp_d = 1'b0;
        end

        // Out-of-range indices simply match no slot.
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_write && (bp_index == BP_IDX_W'(i))) begin
                bp_addr_d[i] = bp_addr_in;
                bp_en_d[i]   = bp_en_in;
            end
        end
    end

    // ---------------- read port ----------------
    always_comb begin
        rd_busy_d   = rd_busy_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        bank_sel_d  = bank_sel_q;
        bank_addr_d = bank_addr_q;
        if (rd_busy_q) begin
            // Mux has had a full cycle to settle on the registered select.
            rd_data_d  = bank_data;
            rd_valid_d = 1'b1;
            rd_busy_d  = 1'b0;
        end else if (rd_req) begin
            bank_sel_d  = rd_sel;
            bank_addr_d = rd_addr;
            rd_busy_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            skip_bp_q   <= 1'b0;
            bp_hit_q    <= 1'b0;
            bp_id_q     <= '0;
            instret_q   <= '0;
            bp_addr_q   <= '0;
            bp_en_q     <= '0;
            rd_busy_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            bank_sel_q  <= '0;
            bank_addr_q <= '0;
        end else begin
            skip_bp_q   <= skip_bp_d;
            bp_hit_q    <= bp_hit_d;
            bp_id_q     <= bp_id_d;
            instret_q   <= instret_d;
            bp_addr_q   <= bp_addr_d;
            bp_en_q     <= bp_en_d;
            rd_busy_q   <= rd_busy_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            bank_sel_q  <= bank_sel_d;
            bank_addr_q <= bank_addr_d;
        end
    end

    assign bp_hit    = bp_hit_q;
    assign bp_id     = bp_id_q;
    assign instret   = instret_q;
    assign rd_busy   = rd_busy_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign bank_sel  = bank_sel_q;
    assign bank_addr = bank_addr_q;

endmodule

// File: tb/tb_mips_debug_unit.sv
// ---------------------------------------------------------------------------
// tb_mips_debug_unit
//
// Self-checking bench for mips_debug_unit. A behavioural model of the run
// control and read port is evaluated at every falling edge and compared with
// two instances: the default 32-bit unit and an 8-bit copy that shares the
// same run-control stimulus so the instret wrap is reached in a few hundred
// cycles. Directed scenarios add hand-computed expectations, then a long
// randomized phase follows.
// ---------------------------------------------------------------------------
module tb_mips_debug_unit;

    localparam int NUM_BP = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        run_req, halt_req, step_req;
    logic        bp_write;
    logic [2:0]  bp_index;
    logic [31:0] bp_addr_in;
    logic        bp_en_in;
    logic [31:0] pc;
    logic        core_enable, halted, bp_hit;
    logic [2:0]  bp_id;
    logic [31:0] instret;
    logic        rd_req;
    logic [1:0]  rd_sel;
    logic [9:0]  rd_addr;
    logic        rd_busy;
    logic [1:0]  bank_sel;
    logic [9:0]  bank_addr;
    logic [31:0] bank_data;
    logic        rd_valid;
    logic [31:0] rd_data;

    // 8-bit instance outputs
    logic        s_ce, s_halted, s_hit, s_busy, s_valid;
    logic [2:0]  s_id;
    logic [7:0]  s_instret, s_rdata;
    logic [1:0]  s_bsel;
    logic [1:0]  s_baddr;

    // core model: pc advances by 4 per retired instruction, kept below 256
    logic        pc_load;
    logic [31:0] pc_load_val;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] bank_fn(input logic [1:0] s, input logic [9:0] a);
        if (s == 2'd1 && a == 10'd5) return 32'hDEAD_BEEF;
        return (32'hA5A5_0000 | {20'h0, s, a}) ^ {a, 22'h0};
    endfunction

    assign bank_data = bank_fn(bank_sel, bank_addr);

    mips_debug_unit dut (
        .clk(clk), .reset(reset),
        .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
        .bp_write(bp_write), .bp_index(bp_index), .bp_addr_in(bp_addr_in),
        .bp_en_in(bp_en_in), .pc(pc),
        .core_enable(core_enable), .halted(halted), .bp_hit(bp_hit),
        .bp_id(bp_id), .instret(instret),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_addr(rd_addr), .rd_busy(rd_busy),
        .bank_sel(bank_sel), .bank_addr(bank_addr), .bank_data(bank_data),
        .rd_valid(rd_valid), .rd_data(rd_data)
    );

    mips_debug_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .NUM_BP(2), .BP_IDX_W(3)) u_small (
        .clk(clk), .reset(reset),
        .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
        .bp_write(bp_write), .bp_index(bp_index), .bp_addr_in(bp_addr_in[7:0]),
        .bp_en_in(bp_en_in), .pc(pc[7:0]),
        .core_enable(s_ce), .halted(s_halted), .bp_hit(s_hit),
        .bp_id(s_id), .instret(s_instret),
        .rd_req(1'b0), .rd_sel(2'd0), .rd_addr(2'd0), .rd_busy(s_busy),
        .bank_sel(s_bsel), .bank_addr(s_baddr), .bank_data(8'h00),
        .rd_valid(s_valid), .rd_data(s_rdata)
    );

    always @(posedge clk) begin
        if (reset)        pc <= 32'h0;
        else if (pc_load) pc <= pc_load_val;
        else if (core_enable) pc <= (pc + 32'd4) & 32'h0000_00FC;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_st: 0 halted, 1 running, 2 single step
    int          m_st;
    logic        m_init = 1'b0;
    logic        m_skip, m_hit;
    logic [2:0]  m_id;
    logic [31:0] m_instret;
    logic [31:0] m_bpa [NUM_BP];
    logic        m_bpe [NUM_BP];
    logic        m_busy, m_valid;
    logic [1:0]  m_rsel;
    logic [9:0]  m_raddr;
    logic [31:0] m_rdata;

    always @(negedge clk) begin
        logic       match;
        logic [2:0] mid;
        logic       exp_ce;
        match = 1'b0;
        mid   = 3'd0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (!match && m_bpe[i] && m_bpa[i] == pc) begin
                match = 1'b1;
                mid   = 3'(i);
            end
        end
        if (m_skip) match = 1'b0;
        exp_ce = (m_st == 1) ? (!halt_req && !match) : (m_st == 2);

        if (m_init) begin
            check("core_enable", 64'(core_enable), 64'(exp_ce));
            check("halted",      64'(halted),      64'(m_st == 0));
            check("bp_hit",      64'(bp_hit),      64'(m_hit));
            check("bp_id",       64'(bp_id),       64'(m_id));
            check("instret",     64'(instret),     64'(m_instret));
            check("rd_busy",     64'(rd_busy),     64'(m_busy));
            check("rd_valid",    64'(rd_valid),    64'(m_valid));
            check("rd_data",     64'(rd_data),     64'(m_rdata));
            if (m_busy) check("bank_sel_addr", 64'({bank_sel, bank_addr}), 64'({m_rsel, m_raddr}));
            check("small_ce_halted", 64'({s_ce, s_halted, s_hit, s_id}), 64'({exp_ce, m_st == 0, m_hit, m_id}));
            check("small_instret", 64'(s_instret), 64'(m_instret[7:0]));
            check("small_rd_idle", 64'({s_busy, s_valid, s_rdata, s_bsel, s_baddr}), 64'(0));
        end

        if (reset) begin
            m_init = 1'b1;
            m_st = 0; m_skip = 0; m_hit = 0; m_id = 0; m_instret = 0;
            for (int i = 0; i < NUM_BP; i++) begin m_bpa[i] = 0; m_bpe[i] = 0; end
            m_busy = 0; m_valid = 0; m_rsel = 0; m_raddr = 0; m_rdata = 0;
        end else if (m_init) begin
            if (exp_ce) m_instret = m_instret + 1;
            case (m_st)
                0: if (!halt_req) begin
                       if (step_req) begin m_st = 2; m_hit = 0; end
                       else if (run_req) begin m_st = 1; m_skip = 1; m_hit = 0; end
                   end
                1: begin
                       if (halt_req) m_st = 0;
                       else if (match) begin m_st = 0; m_hit = 1; m_id = mid; end
                       if (exp_ce) m_skip = 0;
                   end
                default: m_st = 0;
            endcase
            if (bp_write && bp_index < NUM_BP) begin
                m_bpa[bp_index] = bp_addr_in;
                m_bpe[bp_index] = bp_en_in;
            end
            m_valid = m_busy;
            if (m_busy) begin
                m_rdata = bank_fn(m_rsel, m_raddr);
                m_busy  = 0;
            end else if (rd_req) begin
                m_busy = 1; m_rsel = rd_sel; m_raddr = rd_addr;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic next();
        @(posedge clk); #1;
        run_req = 0; halt_req = 0; step_req = 0; bp_write = 0; rd_req = 0; pc_load = 0;
    endtask

    task automatic do_reset();
        reset = 1; next(); next(); reset = 0;
    endtask

    task automatic write_bp(input int idx, input logic [31:0] a, input logic en);
        bp_write = 1; bp_index = 3'(idx); bp_addr_in = a; bp_en_in = en; next();
    endtask

    initial begin
        int cnt;
        int found;
        reset = 1; run_req = 0; halt_req = 0; step_req = 0; bp_write = 0;
        bp_index = 0; bp_addr_in = 0; bp_en_in = 0; rd_req = 0; rd_sel = 0;
        rd_addr = 0; pc_load = 0; pc_load_val = 0;
        do_reset();

        // reset state
        check("reset_halted",  64'(halted), 64'd1);
        check("reset_instret", 64'(instret), 64'd0);
        check("reset_bp",      64'({bp_hit, bp_id, rd_busy, rd_valid}), 64'd0);

        // three single steps, 4 cycles apart
        cnt = 0;
        repeat (3) begin
            step_req = 1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk); cnt += int'(core_enable); next();
            end
            check("step_halted", 64'(halted), 64'd1);
        end
        check("step_ce_count", 64'(cnt), 64'd3);
        check("step_instret",  64'(instret), 64'd3);

        // breakpoint on slot 1 at 0x10
        do_reset();
        write_bp(1, 32'h10, 1'b1);
        run_req = 1; next();
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(negedge clk);
            if (pc == 32'h10) begin
                found = 1;
                check("bp_ce_low", 64'(core_enable), 64'd0);
            end
            next();
        end
        check("bp_reached", 64'(found), 64'd1);
        check("bp_stop", 64'({halted, bp_hit, bp_id}), 64'({1'b1, 1'b1, 3'd1}));
        check("bp_instret", 64'(instret), 64'd4);
        run_req = 1; next();
        @(negedge clk); check("resume_ce", 64'(core_enable), 64'd1);
        next(); next();
        check("resume_pc", 64'(pc), 64'h18);
        check("resume_running", 64'({halted, bp_hit}), 64'd0);
        halt_req = 1; next();

        // two slots at same address: lowest slot reported
        do_reset();
        write_bp(0, 32'h8, 1'b1);
        write_bp(1, 32'h8, 1'b1);
        run_req = 1; next();
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            if (halted) found = 1; else next();
        end
        check("dual_stop", 64'(found), 64'd1);
        check("dual_bp_id", 64'({bp_hit, bp_id}), 64'({1'b1, 3'd0}));
        check("dual_instret", 64'(instret), 64'd2);
        halt_req = 1; run_req = 1; next();
        check("halt_beats_run", 64'(halted), 64'd1);
        @(negedge clk); check("halt_run_ce", 64'(core_enable), 64'd0);
        next();

        // halt while running
        do_reset();
        run_req = 1; next();
        next(); next(); next(); next();
        halt_req = 1;
        @(negedge clk); check("halt_ce_same_cycle", 64'(core_enable), 64'd0);
        next();
        check("halt_next_cycle", 64'(halted), 64'd1);
        check("halt_instret", 64'(instret), 64'd4);

        // instret wrap on the 8-bit instance
        do_reset();
        run_req = 1; next();
        repeat (256) next();
        check("wide_instret_256", 64'(instret), 64'd256);
        check("small_wrap", 64'(s_instret), 64'd0);
        next();
        check("small_after_wrap", 64'(s_instret), 64'd1);
        halt_req = 1; next();

        // debug read with a back-to-back request in the busy cycle
        rd_req = 1; rd_sel = 2'd1; rd_addr = 10'd5; next();
        check("rd_busy_set", 64'({rd_busy, bank_sel, bank_addr}), 64'({1'b1, 2'd1, 10'd5}));
        rd_req = 1; rd_sel = 2'd3; rd_addr = 10'd7; next();
        @(negedge clk);
        check("rd_valid", 64'(rd_valid), 64'd1);
        check("rd_data",  64'(rd_data), 64'hDEAD_BEEF);
        next();
        @(negedge clk);
        check("rd_ignored", 64'({rd_valid, rd_busy}), 64'd0);
        next();

        // reset aborts an in-flight read
        rd_req = 1; rd_sel = 2'd2; rd_addr = 10'd1; next();
        reset = 1; next(); reset = 0;
        @(negedge clk);
        check("rd_abort", 64'({rd_valid, rd_busy}), 64'd0);
        check("rd_abort_data", 64'(rd_data), 64'd0);
        check("rd_abort_halted", 64'(halted), 64'd1);
        next();
        @(negedge clk); check("rd_abort_no_pulse", 64'(rd_valid), 64'd0);
        next();

        // randomized phase
        for (int c = 0; c < 4000; c++) begin
            int r;
            r = int'($urandom_range(0, 999));
            halt_req = (r < 40);
            r = int'($urandom_range(0, 999));
            step_req = (r < 50);
            r = int'($urandom_range(0, 999));
            run_req  = (r < 90);
            if ($urandom_range(0, 99) < 5) begin
                bp_write = 1;
                bp_index = 3'($urandom_range(0, 3));
                bp_addr_in = 32'($urandom_range(0, 63)) << 2;
                bp_en_in = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 99) < 35) begin
                rd_req = 1;
                rd_sel = 2'($urandom_range(0, 3));
                rd_addr = 10'($urandom_range(0, 1023));
            end
            if ($urandom_range(0, 99) < 3) begin
                pc_load = 1;
                pc_load_val = 32'($urandom_range(0, 63)) << 2;
            end
            reset = ($urandom_range(0, 999) < 4);
            next();
        end
        reset = 0;
        next(); next();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
